pkt_proc_mvc: RTL and testbench

//  Multi-VC packet processor between the AXI slave packet buffers and the router local port.
//  TX: frames flits into HEAD/BODY/TAIL with an independent packet counter per VC, so packets on different VCs may interleave.
//  RX: forwards NoC flits to the AXI RX buffers and checks framing per VC against the size in the head flit.

---
 rtl/pkt_proc_mvc.sv | 220 ++++++++++++++++++++++
 tb/tb_pkt_proc_mvc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_proc_mvc.sv
// rtl/pkt_proc_mvc.sv - multi-VC packet framer/checker between AXI packet buffers and router local port
//
// Purpose:
//   TX: tags each outgoing flit HEAD/BODY/TAIL using a per-VC packet counter,
//       so packets on different VCs may interleave beat by beat.
//   RX: forwards router flits to the AXI RX buffers and checks framing per VC
//       against the size carried in the head flit.
//   Saturating packet/error counters are exported for the CSR block.
//
// Ports:
//   clk_axi, arst_axi                  clock, synchronous active-high reset
//   tx_valid_i/tx_ready_o/tx_vc_i      AXI-side TX handshake and VC select
//   tx_pkt_sz_i, tx_data_i             packet size (head beat only), payload
//   noc_tx_valid_o/noc_tx_ready_i      router TX handshake (ready is per VC)
//   noc_tx_flit_o, noc_tx_vc_o         {type, payload} and VC to router
//   noc_rx_valid_i/noc_rx_ready_o      router RX handshake
//   noc_rx_flit_i, noc_rx_vc_i         flit and VC from router
//   rx_valid_o/rx_ready_i              AXI RX buffer handshake
//   rx_data_o, rx_vc_o, rx_ftype_o     payload, VC and type of the RX flit
//   rx_err_o                           registered 1-cycle framing error pulse
//   tx_pkt_cnt_o, rx_pkt_cnt_o         completed packet counters
//   rx_err_cnt_o                       framing error counter

module pkt_proc_mvc #(
    parameter int NumVirtChn    = 3,
    parameter int FlitDataWidth = 32,
    parameter int PktWidth      = 8,
    parameter int HdrSzLsb      = 0,
    parameter int CntWidth      = 16,
    localparam int VcW          = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1,
    localparam int FlitWidth    = FlitDataWidth + 2
) (
    input  logic                     clk_axi,
    input  logic                     arst_axi,
    input  logic                     tx_valid_i,
    output logic                     tx_ready_o,
    input  logic [VcW-1:0]           tx_vc_i,
    input  logic [PktWidth-1:0]      tx_pkt_sz_i,
    input  logic [FlitDataWidth-1:0] tx_data_i,
    output logic                     noc_tx_valid_o,
    input  logic [NumVirtChn-1:0]    noc_tx_ready_i,
    output logic [FlitWidth-1:0]     noc_tx_flit_o,
    output logic [VcW-1:0]           noc_tx_vc_o,
    input  logic                     noc_rx_valid_i,
    output logic                     noc_rx_ready_o,
    input  logic [FlitWidth-1:0]     noc_rx_flit_i,
    input  logic [VcW-1:0]           noc_rx_vc_i,
    output logic                     rx_valid_o,
    input  logic                     rx_ready_i,
    output logic [FlitDataWidth-1:0] rx_data_o,
    output logic [VcW-1:0]           rx_vc_o,
    output logic [1:0]               rx_ftype_o,
    output logic                     rx_err_o,
    output logic [CntWidth-1:0]      tx_pkt_cnt_o,
    output logic [CntWidth-1:0]      rx_pkt_cnt_o,
    output logic [CntWidth-1:0]      rx_err_cnt_o
);

    // Flit type encoding; 2'b11 is undefined and always rejected on RX.
    localparam logic [1:0] FT_HEAD = 2'b00;
    localparam logic [1:0] FT_BODY = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b10;

    // State arrays cover every encodable VC index so an out-of-range VC
    // code can never index past the end of an array.
    localparam int NumVcP = 1 << VcW;

    // ------------------------------------------------------------------
    // TX framing
    // ------------------------------------------------------------------
    logic [NumVcP-1:0]   tx_busy;
    logic [PktWidth-1:0] tx_cnt [NumVcP];
    logic [NumVcP-1:0]   rdy_pad;
    logic [1:0]          tx_ftype;
    logic                tx_fire;
    logic                tx_done;

    // Unimplemented VC codes see a permanently de-asserted ready.
    always_comb begin
        rdy_pad                 = '0;
        rdy_pad[NumVirtChn-1:0] = noc_tx_ready_i;
    end

    assign tx_ready_o = rdy_pad[tx_vc_i];
    assign tx_fire    = tx_valid_i && tx_ready_o;

    always_comb begin
        tx_ftype = FT_HEAD;
        if (tx_busy[tx_vc_i]) begin
            tx_ftype = (tx_cnt[tx_vc_i] != '0) ? FT_BODY : FT_TAIL;
        end
    end

    // A packet completes on its TAIL, or on a size-0 HEAD which is the whole packet.
    assign tx_done = tx_fire &&
                     ((!tx_busy[tx_vc_i] && (tx_pkt_sz_i == '0)) ||
                      ( tx_busy[tx_vc_i] && (tx_cnt[tx_vc_i] == '0)));

    assign noc_tx_valid_o = tx_valid_i;
    assign noc_tx_flit_o  = tx_valid_i ? {tx_ftype, tx_data_i} : '0;
    assign noc_tx_vc_o    = tx_vc_i;

    always_ff @(posedge clk_axi) begin
        if (arst_axi) begin
            tx_busy <= '0;
            for (int i = 0; i < NumVcP; i++) begin
                tx_cnt[i] <= '0;
            end
        end else if (tx_fire) begin
            if (!tx_busy[tx_vc_i]) begin
                if (tx_pkt_sz_i != '0) begin
                    tx_busy[tx_vc_i] <= 1'b1;
                    tx_cnt[tx_vc_i]  <= tx_pkt_sz_i - 1'b1;
                end
            end else if (tx_cnt[tx_vc_i] != '0) begin
                tx_cnt[tx_vc_i] <= tx_cnt[tx_vc_i] - 1'b1;
            end else begin
                tx_busy[tx_vc_i] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX checking
    // ------------------------------------------------------------------
    logic [NumVcP-1:0]   rx_inpkt;
    logic [PktWidth-1:0] rx_rcnt [NumVcP];
    logic [1:0]          rx_ftype;
    logic [PktWidth-1:0] rx_sz;
    logic                rx_fire;
    logic                rx_bad;
    logic                rx_done;
    logic                rx_nxt_in;
    logic [PktWidth-1:0] rx_nxt_cnt;

    assign rx_ftype = noc_rx_flit_i[FlitWidth-1 -: 2];
    assign rx_sz    = noc_rx_flit_i[HdrSzLsb +: PktWidth];
    assign rx_fire  = noc_rx_valid_i && rx_ready_i;

    assign noc_rx_ready_o = rx_ready_i;
    assign rx_valid_o     = noc_rx_valid_i;
    assign rx_data_o      = noc_rx_flit_i[FlitDataWidth-1:0];
    assign rx_vc_o        = noc_rx_vc_i;
    assign rx_ftype_o     = rx_ftype;

    // Next state of the addressed VC. Errored flits are still forwarded; a
    // HEAD always (re)starts a packet, anything else that is out of place
    // drops the VC back to IDLE.
    always_comb begin
        rx_bad     = 1'b0;
        rx_done    = 1'b0;
        rx_nxt_in  = 1'b0;
        rx_nxt_cnt = '0;
        case (rx_ftype)
            FT_HEAD: begin
                rx_bad = rx_inpkt[noc_rx_vc_i];
                if (rx_sz == '0) begin
                    rx_done = 1'b1;
                end else begin
                    rx_nxt_in  = 1'b1;
                    rx_nxt_cnt = rx_sz - 1'b1;
                end
            end
            FT_BODY: begin
                if (rx_inpkt[noc_rx_vc_i] && (rx_rcnt[noc_rx_vc_i] != '0)) begin
                    rx_nxt_in  = 1'b1;
                    rx_nxt_cnt = rx_rcnt[noc_rx_vc_i] - 1'b1;
                end else begin
                    rx_bad = 1'b1;
                end
            end
            FT_TAIL: begin
                if (rx_inpkt[noc_rx_vc_i] && (rx_rcnt[noc_rx_vc_i] == '0)) begin
                    rx_done = 1'b1;
                end else begin
                    rx_bad = 1'b1;
                end
            end
            default: rx_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk_axi) begin
        if (arst_axi) begin
            rx_inpkt <= '0;
            rx_err_o <= 1'b0;
            for (int i = 0; i < NumVcP; i++) begin
                rx_rcnt[i] <= '0;
            end
        end else begin
            rx_err_o <= rx_fire && rx_bad;
            if (rx_fire) begin
                rx_inpkt[noc_rx_vc_i] <= rx_nxt_in;
                rx_rcnt[noc_rx_vc_i]  <= rx_nxt_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating status counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_axi) begin
        if (arst_axi) begin
            tx_pkt_cnt_o <= '0;
            rx_pkt_cnt_o <= '0;
            rx_err_cnt_o <= '0;
        end else begin
            if (tx_done && (tx_pkt_cnt_o != '1)) begin
                tx_pkt_cnt_o <= tx_pkt_cnt_o + 1'b1;
            end
            if (rx_fire && rx_done && (rx_pkt_cnt_o != '1)) begin
                rx_pkt_cnt_o <= rx_pkt_cnt_o + 1'b1;
            end
            if (rx_fire && rx_bad && (rx_err_cnt_o != '1)) begin
                rx_err_cnt_o <= rx_err_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_proc_mvc.sv
// tb/tb_pkt_proc_mvc.sv - scoreboard bench for pkt_proc_mvc

module tb_pkt_proc_mvc;

    localparam logic [1:0] H = 2'b00;
    localparam logic [1:0] B = 2'b01;
    localparam logic [1:0] T = 2'b10;
    localparam logic [1:0] U = 2'b11;

    logic        clk_axi = 1'b0;
    logic        arst_axi;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [1:0]  tx_vc_i;
    logic [7:0]  tx_pkt_sz_i;
    logic [31:0] tx_data_i;
    logic        noc_tx_valid_o;
    logic [2:0]  noc_tx_ready_i;
    logic [33:0] noc_tx_flit_o;
    logic [1:0]  noc_tx_vc_o;
    logic        noc_rx_valid_i;
    logic        noc_rx_ready_o;
    logic [33:0] noc_rx_flit_i;
    logic [1:0]  noc_rx_vc_i;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic [31:0] rx_data_o;
    logic [1:0]  rx_vc_o;
    logic [1:0]  rx_ftype_o;
    logic        rx_err_o;
    logic [15:0] tx_pkt_cnt_o;
    logic [15:0] rx_pkt_cnt_o;
    logic [15:0] rx_err_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;
    bit sb_en    = 1'b0;
    logic pend_err = 1'b0;

    logic [35:0] tx_q [$];   // {type, data, vc}
    logic [36:0] rx_q [$];   // {data, type, vc, err}

    pkt_proc_mvc #(
        .NumVirtChn(3), .FlitDataWidth(32), .PktWidth(8), .HdrSzLsb(0), .CntWidth(16)
    ) dut (
        .clk_axi(clk_axi), .arst_axi(arst_axi),
        .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_vc_i(tx_vc_i),
        .tx_pkt_sz_i(tx_pkt_sz_i), .tx_data_i(tx_data_i),
        .noc_tx_valid_o(noc_tx_valid_o), .noc_tx_ready_i(noc_tx_ready_i),
        .noc_tx_flit_o(noc_tx_flit_o), .noc_tx_vc_o(noc_tx_vc_o),
        .noc_rx_valid_i(noc_rx_valid_i), .noc_rx_ready_o(noc_rx_ready_o),
        .noc_rx_flit_i(noc_rx_flit_i), .noc_rx_vc_i(noc_rx_vc_i),
        .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
        .rx_vc_o(rx_vc_o), .rx_ftype_o(rx_ftype_o), .rx_err_o(rx_err_o),
        .tx_pkt_cnt_o(tx_pkt_cnt_o), .rx_pkt_cnt_o(rx_pkt_cnt_o), .rx_err_cnt_o(rx_err_cnt_o)
    );

    always #5 clk_axi = ~clk_axi;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Monitor: pops the scoreboards whenever a beat fires and checks the
    // registered error pulse one cycle after each RX beat.
    always @(negedge clk_axi) begin
        logic [35:0] te;
        logic [36:0] re;
        if (arst_axi) begin
            pend_err = 1'b0;
        end else if (sb_en) begin
            chk("rx_err_o", rx_err_o, pend_err);
            pend_err = 1'b0;
            chk("noc_rx_ready_o", noc_rx_ready_o, rx_ready_i);
            if (!tx_valid_i) chk("tx_idle", {noc_tx_valid_o, noc_tx_flit_o}, 0);
            if (noc_tx_valid_o && tx_ready_o) begin
                if (tx_q.size() == 0) flag_fail("tx_unexpected_beat");
                else begin
                    te = tx_q.pop_front();
                    chk("tx_beat", {noc_tx_flit_o, noc_tx_vc_o}, te);
                end
            end
            if (rx_valid_o && rx_ready_i) begin
                if (rx_q.size() == 0) flag_fail("rx_unexpected_beat");
                else begin
                    re = rx_q.pop_front();
                    chk("rx_beat", {rx_data_o, rx_ftype_o, rx_vc_o}, re[36:1]);
                    pend_err = re[0];
                end
            end
        end
    end

    task automatic tx_beat(input int vc, input int sz, input logic [31:0] d, input logic [1:0] t);
        bit fired = 1'b0;
        logic [1:0] v = vc[1:0];
        tx_q.push_back({t, d, v});
        tx_valid_i = 1'b1; tx_vc_i = v; tx_pkt_sz_i = sz[7:0]; tx_data_i = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_axi);
            if (tx_ready_o) begin fired = 1'b1; break; end
        end
        if (!fired) begin
            n_assert++; n_fail++;
            $display("FAIL tx_timeout: got no ready, expected ready within 20 cycles");
            void'(tx_q.pop_back());
        end
        @(posedge clk_axi); #1;
        tx_valid_i = 1'b0;
    endtask

    task automatic rx_beat(input int vc, input logic [1:0] t, input logic [31:0] d, input logic err);
        bit fired = 1'b0;
        logic [1:0] v = vc[1:0];
        rx_q.push_back({d, t, v, err});
        noc_rx_valid_i = 1'b1; noc_rx_vc_i = v; noc_rx_flit_i = {t, d};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_axi);
            if (rx_ready_i) begin fired = 1'b1; break; end
        end
        if (!fired) begin
            n_assert++; n_fail++;
            $display("FAIL rx_timeout: got no ready, expected ready within 20 cycles");
            void'(rx_q.pop_back());
        end
        @(posedge clk_axi); #1;
        noc_rx_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk_axi); #1;
        arst_axi = 1'b1;
        repeat (2) @(posedge clk_axi);
        #1 arst_axi = 1'b0;
    endtask

    initial begin
        arst_axi = 1'b1; tx_valid_i = 1'b0; tx_vc_i = '0; tx_pkt_sz_i = '0; tx_data_i = '0;
        noc_tx_ready_i = 3'b111; noc_rx_valid_i = 1'b0; noc_rx_flit_i = '0; noc_rx_vc_i = '0;
        rx_ready_i = 1'b1;
        repeat (3) @(posedge clk_axi);
        #1 arst_axi = 1'b0;
        sb_en = 1'b1;
        @(negedge clk_axi);
        chk("reset_tx_cnt", tx_pkt_cnt_o, 0);
        chk("reset_rx_cnt", rx_pkt_cnt_o, 0);
        chk("reset_err_cnt", rx_err_cnt_o, 0);
        chk("reset_rx_err", rx_err_o, 0);
        @(posedge clk_axi); #1;

        // 1: VC0 size 3
        tx_beat(0, 3, 32'hA000_0003, H);
        tx_beat(0, 0, 32'hA000_0001, B);
        tx_beat(0, 9, 32'hA000_0002, B);
        tx_beat(0, 0, 32'hA000_0003, T);
        chk("t1_tx_cnt", tx_pkt_cnt_o, 1);

        // 2: size-0 packet on VC1, then a fresh head on VC1
        tx_beat(1, 0, 32'hB000_0000, H);
        chk("t2_tx_cnt", tx_pkt_cnt_o, 2);
        tx_beat(1, 2, 32'hB100_0002, H);
        tx_beat(1, 0, 32'hB100_0001, B);
        tx_beat(1, 0, 32'hB100_0002, T);
        chk("t2b_tx_cnt", tx_pkt_cnt_o, 3);

        // 3: interleave VC0 sz=2 and VC2 sz=1 with VC0 ready low for 3 cycles
        noc_tx_ready_i = 3'b110;
        fork
            begin repeat (3) @(posedge clk_axi); #1 noc_tx_ready_i = 3'b111; end
        join_none
        tx_beat(0, 2, 32'hC000_0002, H);
        tx_beat(2, 1, 32'hD000_0001, H);
        tx_beat(0, 0, 32'hC000_0001, B);
        tx_beat(2, 0, 32'hD000_0002, T);
        chk("t3_vc2_done", tx_pkt_cnt_o, 4);
        tx_beat(0, 0, 32'hC000_0003, T);
        chk("t3_vc0_done", tx_pkt_cnt_o, 5);

        // 4: RX good packet on VC1 with a short buffer stall
        rx_ready_i = 1'b0;
        fork
            begin repeat (2) @(posedge clk_axi); #1 rx_ready_i = 1'b1; end
        join_none
        rx_beat(1, H, 32'hABCD_0002, 1'b0);
        rx_beat(1, B, 32'h1111_1111, 1'b0);
        rx_beat(1, T, 32'h2222_2222, 1'b0);
        chk("t4_rx_cnt", rx_pkt_cnt_o, 1);
        chk("t4_err_cnt", rx_err_cnt_o, 0);

        // 5: RX errors and recovery
        rx_beat(0, B, 32'h3333_3333, 1'b1);
        chk("t5_err_cnt1", rx_err_cnt_o, 1);
        rx_beat(2, H, 32'h0000_0001, 1'b0);
        rx_beat(2, H, 32'h5500_0001, 1'b1);
        rx_beat(2, T, 32'h4444_4444, 1'b0);
        chk("t5_rx_cnt", rx_pkt_cnt_o, 2);
        rx_beat(0, U, 32'h6666_6666, 1'b1);
        chk("t5_err_cnt3", rx_err_cnt_o, 3);

        // 6: reset mid-packet on both paths
        tx_beat(0, 3, 32'hE000_0003, H);
        tx_beat(0, 0, 32'hE000_0001, B);
        rx_beat(1, H, 32'h0000_0002, 1'b0);
        repeat (2) @(posedge clk_axi);
        do_reset();
        @(negedge clk_axi);
        chk("t6_tx_cnt0", tx_pkt_cnt_o, 0);
        chk("t6_rx_cnt0", rx_pkt_cnt_o, 0);
        chk("t6_err_cnt0", rx_err_cnt_o, 0);
        @(posedge clk_axi); #1;
        tx_beat(0, 1, 32'hF000_0001, H);
        tx_beat(0, 0, 32'hF000_0002, T);
        chk("t6_tx_cnt1", tx_pkt_cnt_o, 1);
        rx_beat(1, B, 32'h7777_7777, 1'b1);
        chk("t6_err_cnt1", rx_err_cnt_o, 1);
        repeat (2) @(posedge clk_axi);
        #1;
        chk("tx_q_empty", tx_q.size(), 0);
        chk("rx_q_empty", rx_q.size(), 0);

        // Saturation: size-0 packets on both paths every cycle
        sb_en = 1'b0;
        tx_valid_i = 1'b1; tx_vc_i = 2'd1; tx_pkt_sz_i = 8'd0; tx_data_i = '0;
        noc_rx_valid_i = 1'b1; noc_rx_vc_i = 2'd0; noc_rx_flit_i = {H, 32'h0};
        repeat (65535) @(posedge clk_axi);
        #1;
        tx_valid_i = 1'b0; noc_rx_valid_i = 1'b0;
        chk("sat_tx_cnt", tx_pkt_cnt_o, 16'hFFFF);
        chk("sat_rx_cnt_exact", rx_pkt_cnt_o, 16'hFFFF);
        tx_valid_i = 1'b1; noc_rx_valid_i = 1'b1;
        @(posedge clk_axi); #1;
        tx_valid_i = 1'b0; noc_rx_valid_i = 1'b0;
        chk("sat_tx_hold", tx_pkt_cnt_o, 16'hFFFF);
        chk("sat_rx_hold", rx_pkt_cnt_o, 16'hFFFF);
        chk("sat_err_cnt", rx_err_cnt_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
